// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared encodings for the multicycle control sequencer
package multicycle_control_fsm_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLE   = 6'h06;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1a;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  // State codes, also driven on State_Out
  localparam logic [3:0] ST_RESET    = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_IR_LOAD  = 4'd2;
  localparam logic [3:0] ST_DECODE   = 4'd3;
  localparam logic [3:0] ST_EXEC     = 4'd4;
  localparam logic [3:0] ST_MEM_RD   = 4'd5;
  localparam logic [3:0] ST_MEM_WR   = 4'd6;
  localparam logic [3:0] ST_WB       = 4'd7;
  localparam logic [3:0] ST_MD_WAIT  = 4'd8;
  localparam logic [3:0] ST_EXC_SAVE = 4'd9;
  localparam logic [3:0] ST_EXC_LOAD = 4'd10;
  localparam logic [3:0] ST_EXC_JUMP = 4'd11;

  // Datapath mux encodings
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [2:0] PCSRC_ALU    = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_MEM    = 3'b011;
  localparam logic [2:0] PCSRC_A      = 3'b100;

  localparam logic [1:0] IORD_PC  = 2'b00;
  localparam logic [1:0] IORD_ALU = 2'b01;
  localparam logic [1:0] IORD_VEC = 2'b10;

  localparam logic [2:0] RDST_RT = 3'b000;
  localparam logic [2:0] RDST_RD = 3'b001;
  localparam logic [2:0] RDST_RA = 3'b010;
  localparam logic [2:0] RDST_SP = 3'b011;

  localparam logic [3:0] MTR_ALUOUT = 4'd0;
  localparam logic [3:0] MTR_MEM    = 4'd1;
  localparam logic [3:0] MTR_PC     = 4'd2;
  localparam logic [3:0] MTR_HI     = 4'd3;
  localparam logic [3:0] MTR_LO     = 4'd4;

  // Exception causes and their vector byte addresses (252 + cause)
  localparam logic [1:0] EXC_NONE   = 2'b00;
  localparam logic [1:0] EXC_OPCODE = 2'b01;
  localparam logic [1:0] EXC_OVF    = 2'b10;
  localparam logic [1:0] EXC_DIVZ   = 2'b11;
  localparam logic [7:0] EXC_VEC_BASE = 8'd252;

  function automatic logic [7:0] exc_vector(input logic [1:0] cause);
    return EXC_VEC_BASE + {6'd0, cause};
  endfunction

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_BRANCH, CLS_LW, CLS_SW, CLS_J,
    CLS_JAL, CLS_JR, CLS_MULT, CLS_DIV, CLS_MFHI, CLS_MFLO
  } instr_class_e;

endpackage

// File: rtl/multicycle_control_fsm_instr_class_decode.sv
// rtl/multicycle_control_fsm_instr_class_decode.sv - OP_Code/Funct to instruction class
module instr_class_decode
  import multicycle_control_fsm_pkg::*;
(
  input  logic [5:0]   op_code_i,
  input  logic [5:0]   funct_i,
  output instr_class_e class_o,
  output logic [2:0]   alu_op_o,
  output logic         ovf_chk_o,
  output logic [1:0]   br_kind_o,
  output logic         illegal_o
);

  // Classify the instruction; anything unrecognised raises illegal_o
  always_comb begin
    class_o   = CLS_ALU_R;
    alu_op_o  = ALU_ADD;
    ovf_chk_o = 1'b0;
    br_kind_o = op_code_i[1:0];  // beq/bne/ble/bgt occupy opcodes 4..7
    illegal_o = 1'b0;
    case (op_code_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  ovf_chk_o = 1'b1;
          FN_SUB:  begin alu_op_o = ALU_SUB; ovf_chk_o = 1'b1; end
          FN_AND:  alu_op_o = ALU_AND;
          FN_SLT:  alu_op_o = ALU_CMP;
          FN_JR:   class_o = CLS_JR;
          FN_MULT: class_o = CLS_MULT;
          FN_DIV:  class_o = CLS_DIV;
          FN_MFHI: class_o = CLS_MFHI;
          FN_MFLO: class_o = CLS_MFLO;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_J:     class_o = CLS_J;
      OP_JAL:   class_o = CLS_JAL;
      OP_BEQ, OP_BNE, OP_BLE, OP_BGT: class_o = CLS_BRANCH;
      OP_ADDI:  begin class_o = CLS_ALU_I; ovf_chk_o = 1'b1; end
      OP_ADDIU: class_o = CLS_ALU_I;
      OP_LW:    class_o = CLS_LW;
      OP_SW:    class_o = CLS_SW;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS-subset control sequencer
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int         MEM_WAIT    = 1,
  parameter logic [3:0] SP_INIT_SEL = 4'd9
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] OP_Code,
  input  logic [5:0] Funct,
  input  logic       EQ,
  input  logic       GT,
  input  logic       Overflow,
  input  logic       Div_Zero,
  input  logic       MD_Done,
  output logic       Reset_Signal,
  output logic       PC_Write,
  output logic [2:0] PC_Src,
  output logic [1:0] IorD,
  output logic       Mem_WR,
  output logic       IR_Write,
  output logic       A_Write,
  output logic       B_Write,
  output logic       ALU_SrcA,
  output logic [1:0] ALU_SrcB,
  output logic [2:0] ALU_Op,
  output logic       ALUOut_Write,
  output logic       Reg_Write,
  output logic [2:0] Reg_Dst,
  output logic [3:0] MemToReg,
  output logic       MD_Start,
  output logic       MD_Op,
  output logic       HI_Write,
  output logic       LO_Write,
  output logic       EPC_Write,
  output logic [1:0] Exc_Cause,
  output logic [3:0] State_Out
);

  // FETCH/EXC_LOAD end on WAIT_LAST; MEM_RD runs one extra capture cycle up to WAIT_DONE
  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);
  localparam logic [2:0] WAIT_DONE = 3'(MEM_WAIT);

  logic [3:0]   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [1:0]   exc_q, exc_d;
  instr_class_e cls_q, dec_cls;
  logic [2:0]   alu_op_q, dec_alu_op;
  logic         ovf_chk_q, dec_ovf_chk;
  logic [1:0]   br_kind_q, dec_br_kind;
  logic         dec_illegal;
  logic         br_taken;

  instr_class_decode u_decode (
    .op_code_i (OP_Code),
    .funct_i   (Funct),
    .class_o   (dec_cls),
    .alu_op_o  (dec_alu_op),
    .ovf_chk_o (dec_ovf_chk),
    .br_kind_o (dec_br_kind),
    .illegal_o (dec_illegal)
  );

  // Branch condition from the compare flags of the A/B registers
  always_comb begin
    case (br_kind_q)
      2'd0:    br_taken = EQ;
      2'd1:    br_taken = !EQ;
      2'd2:    br_taken = EQ || !GT;
      default: br_taken = GT;
    endcase
  end

  // Next state, exception cause, and per-state wait counter
  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    case (state_q)
      ST_RESET:    if (cnt_q != 3'd0) state_d = ST_FETCH;
      ST_FETCH:    if (cnt_q == WAIT_LAST) state_d = ST_IR_LOAD;
      ST_IR_LOAD:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_EXC_SAVE;
          exc_d   = EXC_OPCODE;
        end else begin
          state_d = ST_EXEC;
          exc_d   = EXC_NONE;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_ALU_R, CLS_ALU_I: begin
            if (ovf_chk_q && Overflow) begin
              state_d = ST_EXC_SAVE;
              exc_d   = EXC_OVF;
            end else begin
              state_d = ST_WB;
            end
          end
          CLS_MFHI, CLS_MFLO: state_d = ST_WB;
          CLS_LW:             state_d = ST_MEM_RD;
          CLS_SW:             state_d = ST_MEM_WR;
          CLS_MULT:           state_d = ST_MD_WAIT;
          CLS_DIV: begin
            if (Div_Zero) begin
              state_d = ST_EXC_SAVE;
              exc_d   = EXC_DIVZ;
            end else begin
              state_d = ST_MD_WAIT;
            end
          end
          default:            state_d = ST_FETCH;
        endcase
      end
      ST_MEM_RD:   if (cnt_q == WAIT_DONE) state_d = ST_WB;
      ST_MEM_WR:   state_d = ST_FETCH;
      ST_WB:       state_d = ST_FETCH;
      ST_MD_WAIT:  if (MD_Done) state_d = ST_FETCH;
      ST_EXC_SAVE: state_d = ST_EXC_LOAD;
      ST_EXC_LOAD: if (cnt_q == WAIT_LAST) state_d = ST_EXC_JUMP;
      ST_EXC_JUMP: state_d = ST_FETCH;
      default:     state_d = ST_RESET;
    endcase
    cnt_d = (state_d != state_q) ? 3'd0 : cnt_q + 3'd1;
  end

  // State registers; instruction class is captured while in DECODE
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_RESET;
      cnt_q     <= 3'd0;
      exc_q     <= EXC_NONE;
      cls_q     <= CLS_ALU_R;
      alu_op_q  <= ALU_PASS;
      ovf_chk_q <= 1'b0;
      br_kind_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      if (state_q == ST_DECODE) begin
        cls_q     <= dec_cls;
        alu_op_q  <= dec_alu_op;
        ovf_chk_q <= dec_ovf_chk;
        br_kind_q <= dec_br_kind;
      end
    end
  end

  assign Exc_Cause = exc_q;
  assign State_Out = state_q;

  // Datapath controls from state/counter/class; only the branch PC_Write, the div
  // MD_Start and the HI/LO strobes look at same-cycle flags
  always_comb begin
    Reset_Signal = 1'b0;
    PC_Write     = 1'b0;
    PC_Src       = PCSRC_ALU;
    IorD         = IORD_PC;
    Mem_WR       = 1'b0;
    IR_Write     = 1'b0;
    A_Write      = 1'b0;
    B_Write      = 1'b0;
    ALU_SrcA     = 1'b0;
    ALU_SrcB     = SRCB_B;
    ALU_Op       = ALU_PASS;
    ALUOut_Write = 1'b0;
    Reg_Write    = 1'b0;
    Reg_Dst      = RDST_RT;
    MemToReg     = MTR_ALUOUT;
    MD_Start     = 1'b0;
    MD_Op        = 1'b0;
    HI_Write     = 1'b0;
    LO_Write     = 1'b0;
    EPC_Write    = 1'b0;
    case (state_q)
      ST_RESET: begin
        // counter 0 is the held-in-reset cycle; counter 1 is the init cycle
        if (cnt_q != 3'd0) begin
          Reset_Signal = 1'b1;
          Reg_Write    = 1'b1;
          Reg_Dst      = RDST_SP;
          MemToReg     = SP_INIT_SEL;
        end
      end
      ST_FETCH: begin
        if (cnt_q == 3'd0) begin
          PC_Write = 1'b1;
          ALU_SrcB = SRCB_FOUR;
          ALU_Op   = ALU_ADD;
        end
      end
      ST_IR_LOAD: IR_Write = 1'b1;
      ST_DECODE: begin
        A_Write      = 1'b1;
        B_Write      = 1'b1;
        ALU_SrcB     = SRCB_IMM_SH;
        ALU_Op       = ALU_ADD;
        ALUOut_Write = 1'b1;
      end
      ST_EXEC: begin
        ALU_SrcA = 1'b1;
        case (cls_q)
          CLS_ALU_R: begin
            ALU_Op       = alu_op_q;
            ALUOut_Write = 1'b1;
          end
          CLS_ALU_I, CLS_LW, CLS_SW: begin
            ALU_SrcB     = SRCB_IMM;
            ALU_Op       = ALU_ADD;
            ALUOut_Write = 1'b1;
          end
          CLS_BRANCH: begin
            ALU_Op   = ALU_CMP;
            PC_Src   = PCSRC_ALUOUT;
            PC_Write = br_taken;
          end
          CLS_J: begin
            PC_Src   = PCSRC_JUMP;
            PC_Write = 1'b1;
          end
          CLS_JAL: begin
            PC_Src    = PCSRC_JUMP;
            PC_Write  = 1'b1;
            Reg_Write = 1'b1;
            Reg_Dst   = RDST_RA;
            MemToReg  = MTR_PC;
          end
          CLS_JR: begin
            PC_Src   = PCSRC_A;
            PC_Write = 1'b1;
          end
          CLS_MULT: MD_Start = 1'b1;
          CLS_DIV: begin
            MD_Op    = 1'b1;
            MD_Start = !Div_Zero;
          end
          default: ;
        endcase
      end
      ST_MEM_RD: if (cnt_q != WAIT_DONE) IorD = IORD_ALU;
      ST_MEM_WR: begin
        IorD   = IORD_ALU;
        Mem_WR = 1'b1;
      end
      ST_WB: begin
        Reg_Write = 1'b1;
        case (cls_q)
          CLS_LW:   MemToReg = MTR_MEM;
          CLS_ALU_R: Reg_Dst = RDST_RD;
          CLS_MFHI: begin Reg_Dst = RDST_RD; MemToReg = MTR_HI; end
          CLS_MFLO: begin Reg_Dst = RDST_RD; MemToReg = MTR_LO; end
          default: ;
        endcase
      end
      ST_MD_WAIT: begin
        MD_Op    = (cls_q == CLS_DIV);
        HI_Write = MD_Done;
        LO_Write = MD_Done;
      end
      ST_EXC_SAVE: begin
        ALU_SrcB  = SRCB_FOUR;
        ALU_Op    = ALU_SUB;
        EPC_Write = 1'b1;
      end
      ST_EXC_LOAD: IorD = IORD_VEC;
      ST_EXC_JUMP: begin
        IorD     = IORD_VEC;
        PC_Src   = PCSRC_MEM;
        PC_Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_EXEC = 4'd4, S_WB = 4'd7;
  localparam logic [3:0] S_MD_WAIT = 4'd8, S_EXC_SAVE = 4'd9, S_EXC_LOAD = 4'd10, S_EXC_JUMP = 4'd11;

  logic       Clock, Reset;
  logic [5:0] OP_Code, Funct;
  logic       EQ, GT, Overflow, Div_Zero, MD_Done;
  logic       Reset_Signal, PC_Write, Mem_WR, IR_Write, A_Write, B_Write;
  logic [2:0] PC_Src, ALU_Op, Reg_Dst;
  logic [1:0] IorD, ALU_SrcB, Exc_Cause;
  logic       ALU_SrcA, ALUOut_Write, Reg_Write, MD_Start, MD_Op;
  logic       HI_Write, LO_Write, EPC_Write;
  logic [3:0] MemToReg, State_Out;

  int vectors = 0;
  int miscompares = 0;
  int c_regw, c_memwr, c_iord1, c_mdstart, c_hilo;
  int n;
  logic [7:0] vec;

  multicycle_control_fsm #(.MEM_WAIT(3), .SP_INIT_SEL(4'd9)) dut (
    .Clock(Clock), .Reset(Reset), .OP_Code(OP_Code), .Funct(Funct),
    .EQ(EQ), .GT(GT), .Overflow(Overflow), .Div_Zero(Div_Zero), .MD_Done(MD_Done),
    .Reset_Signal(Reset_Signal), .PC_Write(PC_Write), .PC_Src(PC_Src), .IorD(IorD),
    .Mem_WR(Mem_WR), .IR_Write(IR_Write), .A_Write(A_Write), .B_Write(B_Write),
    .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_Op(ALU_Op), .ALUOut_Write(ALUOut_Write),
    .Reg_Write(Reg_Write), .Reg_Dst(Reg_Dst), .MemToReg(MemToReg), .MD_Start(MD_Start),
    .MD_Op(MD_Op), .HI_Write(HI_Write), .LO_Write(LO_Write), .EPC_Write(EPC_Write),
    .Exc_Cause(Exc_Cause), .State_Out(State_Out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    c_regw = 0; c_memwr = 0; c_iord1 = 0; c_mdstart = 0; c_hilo = 0;
  endtask

  // Tally strobes of the current cycle, then advance one clock and settle
  task automatic tick();
    #1;
    if (Reg_Write === 1'b1) c_regw++;
    if (Mem_WR === 1'b1) c_memwr++;
    if (IorD === 2'b01) c_iord1++;
    if (MD_Start === 1'b1) c_mdstart++;
    if (HI_Write === 1'b1 && LO_Write === 1'b1) c_hilo++;
    @(posedge Clock);
    #1;
  endtask

  // FETCH is only matched on its first (PC_Write) cycle
  task automatic wait_state(input logic [3:0] target, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(State_Out == target && (target != S_FETCH || PC_Write == 1'b1)) && cnt < 200);
  endtask

  initial begin
    Reset = 1'b1; OP_Code = 6'h00; Funct = 6'h00;
    EQ = 1'b0; GT = 1'b0; Overflow = 1'b0; Div_Zero = 1'b0; MD_Done = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("rst_state", State_Out, S_RESET);
    chk("rst_regw", Reg_Write, 0);
    chk("rst_sig", Reset_Signal, 0);
    chk("rst_exc", Exc_Cause, 0);
    @(posedge Clock); #1;
    chk("rst_held_sig", Reset_Signal, 0);
    Reset = 1'b1;
    tick();
    chk("init_sig", Reset_Signal, 1);
    chk("init_regw", Reg_Write, 1);
    chk("init_regdst", Reg_Dst, 3);
    chk("init_mtr", MemToReg, 9);
    tick();
    chk("fetch_state", State_Out, S_FETCH);
    chk("fetch_pcw", PC_Write, 1);
    chk("fetch_aluop", ALU_Op, 1);
    tick();
    chk("fetch2_pcw", PC_Write, 0);
    #2 Reset = 1'b0;
    #1;
    chk("abort_state", State_Out, S_RESET);
    chk("abort_regw", Reg_Write, 0);
    #1 Reset = 1'b1;
    tick();
    chk("reinit_sig", Reset_Signal, 1);
    chk("reinit_regdst", Reg_Dst, 3);
    tick();
    chk("refetch_state", State_Out, S_FETCH);

    // add: W+4 cycles, write in WB to rd
    OP_Code = 6'h00; Funct = 6'h20; clr();
    wait_state(S_WB, n);
    chk("add_to_wb", n, 6);
    chk("add_wb_regw", Reg_Write, 1);
    chk("add_wb_regdst", Reg_Dst, 1);
    wait_state(S_FETCH, n);
    chk("add_wb_len", n, 1);
    chk("add_regw_cnt", c_regw, 1);

    // lw: address held 3 cycles, WB on cycle 11
    OP_Code = 6'h23; clr();
    wait_state(S_WB, n);
    chk("lw_to_wb", n, 10);
    chk("lw_iord_cycles", c_iord1, 3);
    chk("lw_mtr", MemToReg, 1);
    chk("lw_regdst", Reg_Dst, 0);
    wait_state(S_FETCH, n);
    chk("lw_wb_len", n, 1);

    // sw: W+4 cycles, single Mem_WR
    OP_Code = 6'h2b; clr();
    wait_state(S_FETCH, n);
    chk("sw_len", n, 7);
    chk("sw_memwr_cnt", c_memwr, 1);
    chk("sw_regw_cnt", c_regw, 0);

    // branches
    OP_Code = 6'h04; EQ = 1'b1;
    wait_state(S_EXEC, n);
    chk("beq_to_exec", n, 5);
    chk("beq_t_pcw", PC_Write, 1);
    chk("beq_t_pcsrc", PC_Src, 1);
    wait_state(S_FETCH, n);
    chk("beq_exec_len", n, 1);
    EQ = 1'b0;
    wait_state(S_EXEC, n);
    chk("beq_nt_pcw", PC_Write, 0);
    wait_state(S_FETCH, n);
    OP_Code = 6'h05; EQ = 1'b1;
    wait_state(S_EXEC, n);
    chk("bne_nt_pcw", PC_Write, 0);
    wait_state(S_FETCH, n);
    OP_Code = 6'h07; EQ = 1'b0; GT = 1'b1;
    wait_state(S_EXEC, n);
    chk("bgt_t_pcw", PC_Write, 1);
    wait_state(S_FETCH, n);
    GT = 1'b0;

    // jal: $31 write and PC jump together in EXEC
    OP_Code = 6'h03;
    wait_state(S_EXEC, n);
    chk("jal_pcw", PC_Write, 1);
    chk("jal_pcsrc", PC_Src, 2);
    chk("jal_regw", Reg_Write, 1);
    chk("jal_regdst", Reg_Dst, 2);
    wait_state(S_FETCH, n);
    chk("jal_exec_len", n, 1);

    // addi overflow: exception, no register write
    OP_Code = 6'h08; Overflow = 1'b1; clr();
    wait_state(S_EXC_SAVE, n);
    chk("ovf_to_save", n, 6);
    chk("ovf_epc", EPC_Write, 1);
    chk("ovf_aluop", ALU_Op, 2);
    chk("ovf_cause", Exc_Cause, 2);
    wait_state(S_FETCH, n);
    chk("ovf_tail", n, 5);
    chk("ovf_regw_cnt", c_regw, 0);

    // addiu ignores Overflow; cause cleared after DECODE
    OP_Code = 6'h09; clr();
    wait_state(S_WB, n);
    chk("addiu_to_wb", n, 6);
    chk("addiu_cause", Exc_Cause, 0);
    wait_state(S_FETCH, n);
    chk("addiu_regw_cnt", c_regw, 1);
    Overflow = 1'b0;

    // div by zero
    OP_Code = 6'h00; Funct = 6'h1a; Div_Zero = 1'b1; clr();
    wait_state(S_EXC_SAVE, n);
    chk("dz_to_save", n, 6);
    chk("dz_epc", EPC_Write, 1);
    chk("dz_cause", Exc_Cause, 3);
    tick();
    chk("dz_load_state", State_Out, S_EXC_LOAD);
    chk("dz_iord", IorD, 2);
    wait_state(S_EXC_JUMP, n);
    chk("dz_load_len", n, 3);
    chk("dz_pcsrc", PC_Src, 3);
    chk("dz_pcw", PC_Write, 1);
    wait_state(S_FETCH, n);
    chk("dz_mdstart_cnt", c_mdstart, 0);
    Div_Zero = 1'b0;

    // mult: early MD_Done ignored, result 32 cycles after start
    Funct = 6'h18; clr();
    wait_state(S_EXEC, n);
    chk("mult_start", MD_Start, 1);
    chk("mult_op", MD_Op, 0);
    MD_Done = 1'b1;
    tick();
    MD_Done = 1'b0;
    chk("mult_early_done", State_Out, S_MD_WAIT);
    repeat (31) tick();
    chk("mult_held", State_Out, S_MD_WAIT);
    chk("mult_hilo_early", c_hilo, 0);
    MD_Done = 1'b1;
    #1;
    chk("mult_hi", HI_Write, 1);
    chk("mult_lo", LO_Write, 1);
    tick();
    MD_Done = 1'b0;
    chk("mult_back_fetch", State_Out, S_FETCH);
    chk("mult_hilo_cnt", c_hilo, 1);
    chk("mult_mdstart_cnt", c_mdstart, 1);

    // illegal opcode
    OP_Code = 6'h3f; Funct = 6'h00; clr();
    wait_state(S_EXC_SAVE, n);
    chk("ill_to_save", n, 5);
    chk("ill_cause", Exc_Cause, 1);
    tick();
    chk("ill_iord", IorD, 2);
    vec = 8'd252 + {6'd0, Exc_Cause};
    chk("ill_vector", vec, 253);
    wait_state(S_FETCH, n);
    chk("ill_tail", n, 4);
    chk("ill_regw_cnt", c_regw, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
